sram_march_bist_ctrl: RTL and testbench



---
 rtl/sram_bist_pkg.sv | 50 +++++
 rtl/sram_bist_cmp.sv | 100 ++++++++++
 rtl/sram_march_bist_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sram_march_bist_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_pkg
// Purpose  : Shared types and the March C- element table for the SRAM BIST
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sram_bist_pkg;

    localparam int NumElems = 6;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // March element index (0..NumElems-1)
    typedef logic [2:0] elem_idx_t;

    localparam elem_idx_t c_last_elem = elem_idx_t'(NumElems - 1);

    // One March element: address direction, optional read then optional write
    typedef struct packed {
        logic dir_down;
        logic has_read;
        logic read_val;
        logic has_write;
        logic write_val;
    } elem_cfg_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_cfg_t elem_cfg(input elem_idx_t idx);
        elem_cfg_t cfg;
        case (idx)
            3'd0:    cfg = '{dir_down: 1'b0, has_read: 1'b0, read_val: 1'b0, has_write: 1'b1, write_val: 1'b0};
            3'd1:    cfg = '{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1};
            3'd2:    cfg = '{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0};
            3'd3:    cfg = '{dir_down: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1};
            3'd4:    cfg = '{dir_down: 1'b1, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0};
            3'd5:    cfg = '{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b0, write_val: 1'b0};
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sram_bist_cmp
// Purpose  : Read-data checker: registers each read's expected value and tag,
//            compares against macro DOUT one cycle later, captures the first
//            failure and counts mismatches (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int AddrWidth = 9,
    parameter int DataWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 rd_valid_i,
    input  logic                 rd_val_i,
    input  elem_idx_t            rd_elem_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    input  logic [DataWidth-1:0] dout_i,
    output logic                 fail_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    output elem_idx_t            fail_elem_o,
    output logic [DataWidth-1:0] fail_bits_o,
    output logic [7:0]           err_cnt_o
);

    localparam logic [7:0] c_cnt_max = 8'hFF;

    logic                 r_pend;
    logic [DataWidth-1:0] r_exp;
    elem_idx_t            r_elem;
    logic [AddrWidth-1:0] r_addr;

    logic                 r_fail;
    logic [AddrWidth-1:0] r_fail_addr;
    elem_idx_t            r_fail_elem;
    logic [DataWidth-1:0] r_fail_bits;
    logic [7:0]           r_err_cnt;

    logic [DataWidth-1:0] w_bits;
    logic                 w_mismatch;

    assign w_bits     = r_exp ^ dout_i;
    assign w_mismatch = r_pend && (w_bits != '0);

    // Tag stage: remember what the read issued this cycle should return
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= 1'b0;
            r_exp  <= '0;
            r_elem <= '0;
            r_addr <= '0;
        end else begin
            r_pend <= rd_valid_i && !clear_i;
            if (rd_valid_i) begin
                r_exp  <= {DataWidth{rd_val_i}};
                r_elem <= rd_elem_i;
                r_addr <= rd_addr_i;
            end
        end
    end

    // Result stage: first-failure capture and saturating error count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_bits <= '0;
            r_err_cnt   <= '0;
        end else if (clear_i) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_bits <= '0;
            r_err_cnt   <= '0;
        end else if (w_mismatch) begin
            if (r_err_cnt != c_cnt_max) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (!r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_addr;
                r_fail_elem <= r_elem;
                r_fail_bits <= w_bits;
            end
        end
    end

    assign fail_o      = r_fail;
    assign fail_addr_o = r_fail_addr;
    assign fail_elem_o = r_fail_elem;
    assign fail_bits_o = r_fail_bits;
    assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/sram_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist_ctrl
// Purpose  : March C- self-test sequencer for a single-port SRAM macro BIST
//            port; reports pass/fail and first-failure diagnostics.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int AddrWidth = 9,
    parameter int DataWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    output logic [2:0]           fail_elem_o,
    output logic [DataWidth-1:0] fail_bits_o,
    output logic [7:0]           err_cnt_o,
    output logic                 bist_en_o,
    output logic                 bist_men_o,
    output logic                 bist_wen_o,
    output logic                 bist_ren_o,
    output logic [AddrWidth-1:0] bist_addr_o,
    output logic [DataWidth-1:0] bist_din_o,
    output logic [DataWidth-1:0] bist_bm_o,
    input  logic [DataWidth-1:0] bist_dout_i
);

    localparam logic [AddrWidth-1:0] c_addr_max = {AddrWidth{1'b1}};
    localparam logic [AddrWidth-1:0] c_addr_one = {{(AddrWidth-1){1'b0}}, 1'b1};

    bist_state_e          r_state;
    bist_state_e          w_state_next;
    elem_idx_t            r_elem;
    elem_idx_t            w_elem_next;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth-1:0] w_addr_next;
    logic                 r_phase;      // 0: read slot, 1: write slot of a two-op element
    logic                 w_phase_next;
    logic                 w_clear;

    elem_cfg_t            w_cfg;
    elem_cfg_t            w_next_cfg;
    elem_idx_t            w_elem_inc;
    logic                 w_run;
    logic                 w_is_read;
    logic                 w_is_write;
    logic                 w_last_op;
    logic                 w_addr_term;

    assign w_cfg       = elem_cfg(r_elem);
    assign w_elem_inc  = r_elem + 3'd1;
    assign w_next_cfg  = elem_cfg(w_elem_inc);
    assign w_run       = (r_state == ST_RUN);
    assign w_is_read   = w_cfg.has_read  && (!w_cfg.has_write || !r_phase);
    assign w_is_write  = w_cfg.has_write && (!w_cfg.has_read  ||  r_phase);
    assign w_last_op   = !(w_cfg.has_read && w_cfg.has_write) || r_phase;
    assign w_addr_term = w_cfg.dir_down ? (r_addr == '0) : (r_addr == c_addr_max);

    // State, element, address and phase registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_elem  <= '0;
            r_addr  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_elem  <= w_elem_next;
            r_addr  <= w_addr_next;
            r_phase <= w_phase_next;
        end
    end

    // Next-state and March walk: one op per RUN cycle, abort overrides all
    always_comb begin
        w_state_next = r_state;
        w_elem_next  = r_elem;
        w_addr_next  = r_addr;
        w_phase_next = r_phase;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_next = ST_RUN;
                    w_elem_next  = '0;
                    w_addr_next  = '0;
                    w_phase_next = 1'b0;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last_op) begin
                    w_phase_next = 1'b0;
                    if (w_addr_term) begin
                        if (r_elem == c_last_elem) begin
                            w_state_next = ST_DRAIN;
                        end else begin
                            w_elem_next = w_elem_inc;
                            w_addr_next = w_next_cfg.dir_down ? c_addr_max : '0;
                        end
                    end else begin
                        w_addr_next = w_cfg.dir_down ? (r_addr - c_addr_one)
                                                     : (r_addr + c_addr_one);
                    end
                end else begin
                    w_phase_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            w_state_next = ST_IDLE;
            w_clear      = 1'b0;
        end
    end

    sram_bist_cmp #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_cmp (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (w_clear),
        .rd_valid_i  (w_run && w_is_read),
        .rd_val_i    (w_cfg.read_val),
        .rd_elem_i   (r_elem),
        .rd_addr_i   (r_addr),
        .dout_i      (bist_dout_i),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o),
        .fail_bits_o (fail_bits_o),
        .err_cnt_o   (err_cnt_o)
    );

    // Macro-side controls decode only registered state, never raw inputs
    assign busy_o      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_o      = (r_state == ST_DONE);
    assign bist_en_o   = busy_o;
    assign bist_men_o  = w_run;
    assign bist_wen_o  = w_run && w_is_write;
    assign bist_ren_o  = w_run && w_is_read;
    assign bist_addr_o = w_run ? r_addr : '0;
    assign bist_din_o  = (w_run && w_is_write) ? {DataWidth{w_cfg.write_val}} : '0;
    assign bist_bm_o   = {DataWidth{1'b1}};

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_bist_ctrl
// Purpose  : Scoreboard bench for the March C- BIST sequencer with a
//            behavioural SRAM carrying injectable stuck-at faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist_ctrl;

    localparam int AW      = 9;
    localparam int DW      = 16;
    localparam int N       = 1 << AW;
    localparam int RUN_LAT = 10 * N + 2;   // cycle index (1 = cycle after start edge) of first done
    localparam int HALF_OPS = 5 * N;       // writes per run, also reads per run

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_bits;
    logic [7:0]    err_cnt;
    logic          b_en, b_men, b_wen, b_ren;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din, b_bm;
    logic [DW-1:0] b_dout = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // March C- described as data: -1 = no op, otherwise the value read/written
    int el_rd [6] = '{-1, 0, 1, 0, 1, 0};
    int el_wr [6] = '{ 0, 1, 0, 1, 0, -1};
    int el_dn [6] = '{ 0, 0, 0, 1, 1, 0};

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct packed {
        logic          fail;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
        logic [DW-1:0] bits;
        logic [7:0]    cnt;
    } res_t;

    op_t  q_ops [$];
    res_t q_res [$];

    logic [DW-1:0] mem [N];
    logic [DW-1:0] sa1 [N];
    logic [DW-1:0] sa0 [N];

    sram_march_bist_ctrl #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .fail_o      (fail),
        .fail_addr_o (fail_addr),
        .fail_elem_o (fail_elem),
        .fail_bits_o (fail_bits),
        .err_cnt_o   (err_cnt),
        .bist_en_o   (b_en),
        .bist_men_o  (b_men),
        .bist_wen_o  (b_wen),
        .bist_ren_o  (b_ren),
        .bist_addr_o (b_addr),
        .bist_din_o  (b_din),
        .bist_bm_o   (b_bm),
        .bist_dout_i (b_dout)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: one-cycle read latency, stuck-at faults seen on read
    always @(posedge clk) begin
        if (b_en && b_men) begin
            if (b_wen) mem[b_addr] <= (b_din & b_bm) | (mem[b_addr] & ~b_bm);
            if (b_ren) b_dout <= (mem[b_addr] | sa1[b_addr]) & ~sa0[b_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    // Reference: walk the March over an idealised array and the fault map
    task automatic build_expected();
        logic [DW-1:0] mm [N];
        logic [DW-1:0] got, want;
        res_t r;
        op_t  o;
        int   a;
        r = '0;
        for (int i = 0; i < N; i++) mm[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (el_dn[e] != 0) ? (N - 1 - i) : i;
                if (el_rd[e] >= 0) begin
                    o.wr = 1'b0; o.addr = AW'(a); o.data = '0;
                    q_ops.push_back(o);
                    got  = (mm[a] | sa1[a]) & ~sa0[a];
                    want = (el_rd[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
                    if (got != want) begin
                        if (!r.fail) begin
                            r.fail = 1'b1;
                            r.addr = AW'(a);
                            r.elem = 3'(e);
                            r.bits = got ^ want;
                        end
                        if (r.cnt != 8'hFF) r.cnt = r.cnt + 8'd1;
                    end
                end
                if (el_wr[e] >= 0) begin
                    o.wr = 1'b1; o.addr = AW'(a);
                    o.data = (el_wr[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
                    q_ops.push_back(o);
                    mm[a] = o.data;
                end
            end
        end
        q_res.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status"}, {busy, done, fail, b_en}, 4'b0000);
        check({tag, "_diag"}, {fail_addr, fail_elem, fail_bits, err_cnt}, '0);
        check({tag, "_ctrl"}, {b_men, b_wen, b_ren, b_addr, b_din}, '0);
        check({tag, "_bm"}, b_bm, {DW{1'b1}});
    endtask

    // Full run: start pulse, optional start pulses while busy, wait for done
    task automatic run_full(input int n_busy_starts, input bit check_clear);
        int p1, p2;
        bit seen;
        build_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (check_clear) begin
            check("clear_on_start", {busy, done, fail, err_cnt}, {1'b1, 1'b0, 1'b0, 8'd0});
        end
        p1 = $urandom_range(10, 2500);
        p2 = $urandom_range(2501, 5000);
        seen = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (n_busy_starts > 0 && c == p1) || (n_busy_starts > 1 && c == p2);
        end
        start = 1'b0;
        check("run_terminates", seen, 1'b1);
        @(negedge clk);
    endtask

    // Monitor: pops expected ops and results as the DUT presents them
    initial begin : monitor
        bit   prev_busy = 1'b0;
        bit   prev_done = 1'b0;
        int   cyc0 = 0, nwr = 0, nrd = 0;
        op_t  e;
        res_t r;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                cyc0 = cyc; nwr = 0; nrd = 0;
            end
            if (b_men) begin
                if (q_ops.size() == 0) begin
                    check("op_unexpected", 1'b1, 1'b0);
                end else begin
                    e = q_ops.pop_front();
                    check("op", {b_bm, b_wen, b_ren, b_addr, (b_wen ? b_din : {DW{1'b0}})},
                                {{DW{1'b1}}, e.wr, ~e.wr, e.addr, (e.wr ? e.data : {DW{1'b0}})});
                end
                if (b_wen) nwr++;
                if (b_ren) nrd++;
            end else begin
                check("idle_ctrl", {b_wen, b_ren}, 2'b00);
            end
            if (done && !prev_done) begin
                check("done_latency", cyc - cyc0 + 1, RUN_LAT);
                check("write_count", nwr, HALF_OPS);
                check("read_count", nrd, HALF_OPS);
                if (q_res.size() == 0) begin
                    check("result_unexpected", 1'b1, 1'b0);
                end else begin
                    r = q_res.pop_front();
                    check("res_fail", fail, r.fail);
                    check("res_addr", fail_addr, r.addr);
                    check("res_elem", fail_elem, r.elem);
                    check("res_bits", fail_bits, r.bits);
                    check("res_cnt", err_cnt, r.cnt);
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int na, nf, k;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("post_reset_idle");

        // Fault-free run with ignored start pulses while busy
        run_full(2, 1'b0);
        check("clean_pass", {fail, err_cnt}, 9'd0);

        // Bit 3 of 0x0A5 stuck-at-1
        clear_faults();
        sa1[9'h0A5] = 16'h0008;
        run_full(0, 1'b0);
        check("sa1_summary", {fail, fail_elem, fail_addr, fail_bits, err_cnt},
              {1'b1, 3'd1, 9'h0A5, 16'h0008, 8'd3});

        // Bit 15 stuck-at-0 everywhere: counter saturates
        clear_faults();
        for (int i = 0; i < N; i++) sa0[i] = 16'h8000;
        run_full(0, 1'b0);
        check("sa0_summary", {fail, fail_elem, fail_addr, fail_bits, err_cnt},
              {1'b1, 3'd2, 9'h000, 16'h8000, 8'd255});

        // Start from DONE after a failed run clears results; busy starts ignored
        clear_faults();
        run_full(2, 1'b1);

        // Abort during cycle 1000 of RUN
        build_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (999) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        q_ops.delete();
        q_res.delete();
        check("abort_idle", {busy, b_en, b_men, b_wen, b_ren, done}, 6'b0);
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        run_full(0, 1'b0);

        // Random stuck-at faults
        for (int t = 0; t < 2; t++) begin
            clear_faults();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                na = $urandom_range(0, N - 1);
                k  = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) sa1[na][k] = 1'b1;
                else                           sa0[na][k] = 1'b1;
            end
            run_full(1, 1'b0);
        end

        // Reset asserted during E3 (cycles 5N+1 .. 7N)
        clear_faults();
        build_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5 * N + 40 + $urandom_range(0, 200)) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q_ops.delete();
        q_res.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("post_reset_quiet", {busy, done, b_men, b_en}, 4'b0);
        end
        check_reset_outputs("post_reset_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
